simd_fetch_ctrl: RTL and testbench

- Instruction sequencer for the SIMD core.
- Owns the program counter and drives the address of the combinational instruction ROM (8-bit address, 16-bit word: opcode[15:12], dest[11:8], src1[7:4], src2[3:0]).
- Registers each fetched word and issues it to the lane decode/execute stage over a valid/ready handshake.
- Resolves JMP and HLT locally, so neither opcode is ever issued to the lanes.

---
 rtl/simd_fetch_ctrl.sv | 111 +++++++++++
 tb/tb_simd_fetch_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_fetch_ctrl.sv
// Instruction sequencer for the SIMD core: owns the PC, fetches from a combinational ROM,
// resolves JMP/HLT locally and issues other words over valid/ready. Optional: SINGLE_STEP_EN.
module simd_fetch_ctrl #(
    parameter logic [7:0] START_ADDR = 8'h00,
    parameter logic [3:0] OP_JMP     = 4'b1111,
    parameter logic [3:0] OP_HLT     = 4'b1110
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
`ifdef SINGLE_STEP_EN
    input  logic        step_mode,
    input  logic        step,
`endif
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [7:0]  pc,
    output logic        busy,
    output logic        halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state, state_d;
    logic [7:0]  pc_d;
    logic [15:0] instr_d;
    logic [3:0]  opcode;
    logic        advance;

    assign opcode   = rom_data[15:12];
    assign rom_addr = pc;

`ifdef SINGLE_STEP_EN
    // In step mode an issuable word waits in FETCH for a step pulse.
    assign advance = !step_mode || step;
`else
    assign advance = 1'b1;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and simulation order cannot change the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= START_ADDR;
            instr <= 16'h0000;
        end else begin
            state <= state_d;
            pc    <= pc_d;
            instr <= instr_d;
        end
    end

    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a value unassigned and infers a latch.
    always_comb begin
        state_d = state;
        pc_d    = pc;
        instr_d = instr;
        unique case (state)
            IDLE, HALT: begin
                if (start) begin
                    pc_d    = START_ADDR;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (opcode == OP_JMP) begin
                    pc_d = rom_data[7:0];
                end else if (opcode == OP_HLT) begin
                    state_d = HALT;
                end else if (advance) begin
                    instr_d = rom_data;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (instr_ready) begin
                    pc_d    = pc + 8'd1;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Valid is a pure decode of ISSUE, so it drops together with an async reset.
    always_comb begin
        busy        = 1'b0;
        halted      = 1'b0;
        instr_valid = 1'b0;
        unique case (state)
            FETCH:   busy = 1'b1;
            ISSUE: begin
                busy        = 1'b1;
                instr_valid = 1'b1;
            end
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_simd_fetch_ctrl.sv
// Self-checking bench for simd_fetch_ctrl: directed scenarios plus randomized programs
// checked against a program-walking reference model.
module tb_simd_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
`ifdef SINGLE_STEP_EN
    logic        step_mode = 1'b0;
    logic        step = 1'b0;
`endif

    logic [15:0] rom [256];
    logic [15:0] issued_words[$];
    logic [7:0]  issued_pcs[$];
    int          n_checks = 0;
    int          n_pass = 0;

    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    simd_fetch_ctrl dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
`ifdef SINGLE_STEP_EN
        .step_mode(step_mode),
        .step(step),
`endif
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .instr(instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .pc(pc),
        .busy(busy),
        .halted(halted)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        start       = 1'b0;
        instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_rom();
        foreach (rom[i]) rom[i] = 16'h0000;
    endtask

    task automatic load_prog_a();
        clear_rom();
        rom[8'h00] = 16'h7202;
        rom[8'h01] = 16'h01CE;
        rom[8'h02] = 16'h211D;
        rom[8'h03] = 16'h4112;
        rom[8'h04] = 16'hF001;
    endtask

    // Reference model: follow jumps from an address to the next issuable word.
    // kind: 0 = issue, 1 = halt, 2 = endless jump loop.
    function automatic void walk(input logic [7:0] from, output int kind,
                                 output logic [7:0] addr, output logic [15:0] word,
                                 output int jumps);
        logic [7:0] a;
        a = from;
        jumps = 0;
        kind = 2;
        addr = from;
        word = 16'h0000;
        for (int s = 0; s < 300; s++) begin
            if (rom[a][15:12] == 4'hF) begin
                a = rom[a][7:0];
                jumps++;
            end else begin
                kind = (rom[a][15:12] == 4'hE) ? 1 : 0;
                addr = a;
                word = rom[a];
                return;
            end
        end
    endfunction

    // Called one cycle after the start pulse edge (DUT fetching START_ADDR).
    task automatic run_program(input int max_issues, input int ready_pct);
        logic [7:0]  cur;
        logic [7:0]  a;
        logic [7:0]  nxt;
        logic [15:0] w;
        int          kind;
        int          jumps;
        cur = 8'h00;
        issued_words.delete();
        issued_pcs.delete();
        for (int n = 0; n < max_issues; n++) begin
            walk(cur, kind, a, w, jumps);
            if (kind == 2) begin
                repeat (5) begin
                    instr_ready = 1'($urandom_range(0, 1));
                    tick();
                    check("spin_busy", busy, 1);
                    check("spin_valid", instr_valid, 0);
                end
                return;
            end
            for (int c = 0; c < jumps; c++) begin
                instr_ready = 1'($urandom_range(0, 1));
                tick();
                check("jump_valid", instr_valid, 0);
                check("jump_busy", busy, 1);
            end
            instr_ready = 1'($urandom_range(0, 1));
            tick();
            if (kind == 1) begin
                check("halt_flag", halted, 1);
                check("halt_pc", pc, a);
                check("halt_busy", busy, 0);
                check("halt_valid", instr_valid, 0);
                return;
            end
            check("issue_valid", instr_valid, 1);
            check("issue_instr", instr, w);
            check("issue_pc", pc, a);
            issued_words.push_back(instr);
            issued_pcs.push_back(pc);
            for (int s = 0; s < 5; s++) begin
                instr_ready = (s >= 4) || ($urandom_range(1, 100) <= ready_pct);
                tick();
                if (instr_ready) break;
                check("hold_valid", instr_valid, 1);
                check("hold_instr", instr, w);
            end
            nxt = a + 8'd1;
            check("ack_valid", instr_valid, 0);
            check("ack_pc", pc, nxt);
            cur = nxt;
        end
    endtask

    initial begin
        logic [15:0] exp_a [7];
        logic [15:0] exp_wrap_w [4];
        logic [7:0]  exp_wrap_pc [4];
        exp_a       = '{16'h7202, 16'h01CE, 16'h211D, 16'h4112, 16'h01CE, 16'h211D, 16'h4112};
        exp_wrap_w  = '{16'h1111, 16'h2222, 16'h1111, 16'h2222};
        exp_wrap_pc = '{8'hFE, 8'hFF, 8'hFE, 8'hFF};

        // Reset state
        clear_rom();
        do_reset();
        check("rst_pc", pc, 8'h00);
        check("rst_addr", rom_addr, 8'h00);
        check("rst_instr", instr, 16'h0000);
        check("rst_valid", instr_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        instr_ready = 1'b1;
        tick();
        check("idle_ready_no_effect", instr_valid, 0);

        // Program A, ready tied high: 2-cycle latency and looping stream
        load_prog_a();
        do_reset();
        pulse_start();
        check("start_busy", busy, 1);
        check("start_valid", instr_valid, 0);
        run_program(7, 100);
        check("a_count", issued_words.size(), 7);
        for (int i = 0; i < 7 && i < issued_words.size(); i++)
            check($sformatf("a_word%0d", i), issued_words[i], exp_a[i]);

        // Ready held low for 5 cycles at first issue; start while busy ignored
        do_reset();
        pulse_start();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", instr_valid, 1);
            check("stall_instr", instr, 16'h7202);
            check("stall_pc", pc, 8'h00);
            tick();
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("stall_ack_pc", pc, 8'h01);
        check("stall_ack_valid", instr_valid, 0);
        tick();
        check("second_instr", instr, 16'h01CE);
        pulse_start();
        check("busy_start_pc", pc, 8'h01);
        check("busy_start_instr", instr, 16'h01CE);
        check("busy_start_valid", instr_valid, 1);

        // Reset mid-ISSUE drops the instruction asynchronously
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", instr_valid, 0);
        check("async_pc", pc, 8'h00);
        check("async_busy", busy, 0);
        check("async_instr", instr, 16'h0000);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) tick();
        check("post_rst_idle", busy, 0);
        pulse_start();
        tick();
        check("resume_valid", instr_valid, 1);
        check("resume_instr", instr, 16'h7202);

        // NOP then HLT, restart from halt
        clear_rom();
        rom[8'h01] = 16'hE000;
        do_reset();
        instr_ready = 1'b1;
        pulse_start();
        tick();
        check("nop_valid", instr_valid, 1);
        check("nop_instr", instr, 16'h0000);
        tick();
        check("nop_ack_pc", pc, 8'h01);
        check("nop_ack_halted", halted, 0);
        tick();
        check("hlt_halted", halted, 1);
        check("hlt_pc", pc, 8'h01);
        check("hlt_busy", busy, 0);
        pulse_start();
        check("restart_pc", pc, 8'h00);
        check("restart_halted", halted, 0);
        tick();
        check("restart_instr", instr, 16'h0000);
        check("restart_valid", instr_valid, 1);

        // Jump to FE, wrap FF -> 00, re-execute the jump
        clear_rom();
        rom[8'h00] = 16'hF0FE;
        rom[8'hFE] = 16'h1111;
        rom[8'hFF] = 16'h2222;
        do_reset();
        pulse_start();
        run_program(4, 70);
        check("wrap_count", issued_words.size(), 4);
        for (int i = 0; i < 4 && i < issued_words.size(); i++) begin
            check($sformatf("wrap_word%0d", i), issued_words[i], exp_wrap_w[i]);
            check($sformatf("wrap_pc%0d", i), issued_pcs[i], exp_wrap_pc[i]);
        end

        // Self-jump spins forever
        clear_rom();
        rom[8'h00] = 16'hF000;
        do_reset();
        pulse_start();
        repeat (8) begin
            tick();
            check("self_busy", busy, 1);
            check("self_valid", instr_valid, 0);
            check("self_pc", pc, 8'h00);
        end

        // Randomized programs in the low 16 addresses
        for (int r = 0; r < 8; r++) begin
            clear_rom();
            for (int a = 0; a < 16; a++) begin
                int k;
                k = $urandom_range(0, 99);
                if (k < 15)
                    rom[a] = {4'hF, 4'h0, 8'($urandom_range(0, 15))};
                else if (k < 20)
                    rom[a] = 16'hE000;
                else
                    rom[a] = {4'($urandom_range(0, 13)), 12'($urandom)};
            end
            do_reset();
            pulse_start();
            run_program(25, 60);
        end

`ifdef SINGLE_STEP_EN
        load_prog_a();
        do_reset();
        step_mode = 1'b1;
        pulse_start();
        repeat (3) begin
            tick();
            check("step_wait_valid", instr_valid, 0);
            check("step_wait_busy", busy, 1);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        check("step1_instr", instr, 16'h7202);
        check("step1_valid", instr_valid, 1);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        repeat (3) begin
            tick();
            check("step_wait2_valid", instr_valid, 0);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        check("step2_instr", instr, 16'h01CE);
        check("step2_pc", pc, 8'h01);
        step_mode = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
